// File: rtl/addsub_seq_32_if.sv
// Bundle of the handshake and data signals for addsub_seq_32.
// ADDSUB_SEQ_CMP_FLAGS_EN adds the isNotEqual / isLessThan comparison flags.
interface addsub_seq_32_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_result;
   logic             cout;
   logic             overflow;
`ifdef ADDSUB_SEQ_CMP_FLAGS_EN
   logic             isNotEqual;
   logic             isLessThan;

   modport master (
      output in_valid, data_operandA, data_operandB, sub, out_ready,
      input  in_ready, out_valid, data_result, cout, overflow, isNotEqual, isLessThan
   );
   modport slave (
      input  in_valid, data_operandA, data_operandB, sub, out_ready,
      output in_ready, out_valid, data_result, cout, overflow, isNotEqual, isLessThan
   );
`else
   modport master (
      output in_valid, data_operandA, data_operandB, sub, out_ready,
      input  in_ready, out_valid, data_result, cout, overflow
   );
   modport slave (
      input  in_valid, data_operandA, data_operandB, sub, out_ready,
      output in_ready, out_valid, data_result, cout, overflow
   );
`endif
endinterface

// File: rtl/addsub_seq_32.sv
// Multi-cycle add/subtract unit: one byte per clock through an 8-bit
// ripple-carry slice, LSB first, carry chained in a register.
// Optional feature macro: ADDSUB_SEQ_CMP_FLAGS_EN (adds isNotEqual / isLessThan).

// 8-bit ripple-carry slice with carry out and signed overflow
module rca_8_overflow (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout,
   output logic       of
);
   logic [7:0] low_s;
   logic [8:0] full_s;

   // carry into bit 7 comes from the low 7 bits; overflow is that xor carry out
   always_comb begin
      low_s  = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'd0, cin};
      full_s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      sum    = full_s[7:0];
      cout   = full_s[8];
      of     = low_s[7] ^ full_s[8];
   end
endmodule

module addsub_seq_32 #(
   parameter int WIDTH = 32
) (
   input  logic           clock,
   input  logic           reset_n,
   addsub_seq_32_if.slave bus
);
   localparam int CHUNKS = WIDTH / 8;
   localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_next_s;
   logic [IDX_W-1:0]   idx_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic               carry_r;
   logic [WIDTH-1:0]   result_r;
   logic               cout_r;
   logic               overflow_r;
   logic               in_ready_s;
   logic               out_valid_s;
   logic               last_s;
   logic [7:0]         slice_sum_s;
   logic               slice_cout_s;
   logic               slice_of_s;
   logic [WIDTH-1:0]   next_result_s;
`ifdef ADDSUB_SEQ_CMP_FLAGS_EN
   logic               sub_r;
   logic               is_not_equal_r;
   logic               is_less_than_r;
`endif

   assign last_s = (idx_r == IDX_W'(CHUNKS - 1));

   rca_8_overflow u_slice (
      .a    (a_r[{idx_r, 3'b000} +: 8]),
      .b    (b_r[{idx_r, 3'b000} +: 8]),
      .cin  (carry_r),
      .sum  (slice_sum_s),
      .cout (slice_cout_s),
      .of   (slice_of_s)
   );

   // result as it will look once the current byte is written back
   always_comb begin
      next_result_s = result_r;
      next_result_s[{idx_r, 3'b000} +: 8] = slice_sum_s;
   end

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // next-state decode: accept in IDLE, step bytes in RUN, hold DONE until consumed
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) begin
               state_next_s = RUN;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = RUN;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DONE;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // handshake outputs decoded from the state register
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      case (state_r)
         IDLE: in_ready_s  = 1'b1;
         DONE: out_valid_s = 1'b1;
         default: begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // operand capture on accept, byte-serial compute while running
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idx_r          <= '0;
         a_r            <= '0;
         b_r            <= '0;
         carry_r        <= 1'b0;
         result_r       <= '0;
         cout_r         <= 1'b0;
         overflow_r     <= 1'b0;
`ifdef ADDSUB_SEQ_CMP_FLAGS_EN
         sub_r          <= 1'b0;
         is_not_equal_r <= 1'b0;
         is_less_than_r <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid) begin
                  // subtraction is A + ~B + 1: invert B here, the +1 rides in as carry
                  a_r     <= bus.data_operandA;
                  b_r     <= bus.data_operandB ^ {WIDTH{bus.sub}};
                  carry_r <= bus.sub;
                  idx_r   <= '0;
`ifdef ADDSUB_SEQ_CMP_FLAGS_EN
                  sub_r   <= bus.sub;
`endif
               end
            end
            RUN: begin
               result_r <= next_result_s;
               carry_r  <= slice_cout_s;
               idx_r    <= idx_r + IDX_W'(1);
               if (last_s) begin
                  cout_r     <= slice_cout_s;
                  overflow_r <= slice_of_s;
`ifdef ADDSUB_SEQ_CMP_FLAGS_EN
                  is_not_equal_r <= sub_r & (|next_result_s);
                  is_less_than_r <= sub_r & (next_result_s[WIDTH-1] ^ slice_of_s);
`endif
               end
            end
            default: begin
               idx_r <= idx_r;
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_s;
   assign bus.out_valid   = out_valid_s;
   assign bus.data_result = result_r;
   assign bus.cout        = cout_r;
   assign bus.overflow    = overflow_r;
`ifdef ADDSUB_SEQ_CMP_FLAGS_EN
   assign bus.isNotEqual  = is_not_equal_r;
   assign bus.isLessThan  = is_less_than_r;
`endif
endmodule

// File: tb/tb_addsub_seq_32.sv
// Self-checking bench for addsub_seq_32: directed corner cases, randomized
// operations, backpressure and mid-operation reset against an arithmetic model.
module tb_addsub_seq_32;
   logic clock;
   logic reset_n;
   int   total;
   int   bad;

   addsub_seq_32_if #(.WIDTH(32)) bus ();

   addsub_seq_32 #(.WIDTH(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full operation; caller is positioned 1 time unit after a rising edge.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int bp);
      longint      sa;
      longint      sb;
      longint      sr;
      logic [32:0] wide;
      logic [31:0] exp_res;
      logic        exp_cout;
      logic        exp_of;
      int          lat;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sr = s ? (sa - sb) : (sa + sb);
      exp_of = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      if (s) begin
         exp_res  = a - b;
         exp_cout = (a >= b);
      end else begin
         wide     = {1'b0, a} + {1'b0, b};
         exp_res  = wide[31:0];
         exp_cout = wide[32];
      end

      check("ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid      = 1'b1;
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.sub           = s;
      @(posedge clock); #1;
      // scramble operands after accept: the op in flight must not notice
      bus.in_valid      = 1'b0;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
      bus.sub           = 1'($urandom_range(0, 1));
      check("busy_after_accept", {31'd0, bus.in_ready}, 32'd0);

      lat = 0;
      do begin
         @(posedge clock); #1;
         lat++;
      end while (!bus.out_valid && lat < 20);
      check("latency", 32'(lat), 32'd4);
      check("result", bus.data_result, exp_res);
      check("cout", {31'd0, bus.cout}, {31'd0, exp_cout});
      check("overflow", {31'd0, bus.overflow}, {31'd0, exp_of});
`ifdef ADDSUB_SEQ_CMP_FLAGS_EN
      check("isNotEqual", {31'd0, bus.isNotEqual}, {31'd0, s & (a != b)});
      check("isLessThan", {31'd0, bus.isLessThan}, {31'd0, s & (sa < sb)});
`endif

      // backpressure with a competing request that must be ignored
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      for (int i = 0; i < bp; i++) begin
         @(posedge clock); #1;
         check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
         check("bp_result", bus.data_result, exp_res);
         check("bp_ready", {31'd0, bus.in_ready}, 32'd0);
      end

      bus.out_ready = 1'b1;
      @(posedge clock); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      check("valid_after_hs", {31'd0, bus.out_valid}, 32'd0);
      check("ready_after_hs", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clock); #1;
      check("not_queued", {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset_n           = 1'b0;
      bus.in_valid      = 1'b0;
      bus.out_ready     = 1'b0;
      bus.data_operandA = 32'd0;
      bus.data_operandB = 32'd0;
      bus.sub           = 1'b0;
      #12;
      check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_result", bus.data_result, 32'd0);
      check("rst_cout", {31'd0, bus.cout}, 32'd0);
      check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
      #5;
      reset_n = 1'b1;
      @(posedge clock); #1;

      run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
      run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0);
      run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 2);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
      run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 0);
      run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 10);

      for (int i = 0; i < 20; i++) begin
         run_op($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      // reset while the third byte is being computed
      bus.in_valid      = 1'b1;
      bus.data_operandA = 32'hFFFF_FFFF;
      bus.data_operandB = 32'h0000_0001;
      bus.sub           = 1'b0;
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset_n = 1'b0;
      #1;
      check("midrst_ready", {31'd0, bus.in_ready}, 32'd1);
      check("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst_result", bus.data_result, 32'd0);
      check("midrst_cout", {31'd0, bus.cout}, 32'd0);
      check("midrst_overflow", {31'd0, bus.overflow}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) begin
         @(posedge clock); #1;
         check("midrst_no_output", {31'd0, bus.out_valid}, 32'd0);
      end
      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
